// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: the value and display controls in,
// the active-low anode/segment/decimal-point drive out.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  // The source of the value (counter/bench) drives the inputs and watches the pins.
  modport master (
    output value, dp_in, blank_lz,
    input  an, seg, dp
  );

  // The scan driver reads the value and controls, and owns the display pins.
  modport slave (
    input  value, dp_in, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode hex display scanner. The value is snapshotted once per
// full scan, each slot starts with a guard time, and leading zeros can be blanked.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_LIM = PW'(GUARD_CYCLES);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [15:0]   r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_in_guard;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_tick = (r_presc == PRESC_MAX);

  // With no guard time the comparison would be constant, so it is elided entirely.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_in_guard = 1'b0;
    end else begin : g_guard
      assign w_in_guard = (r_presc < GUARD_LIM);
    end
  endgenerate

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_digit)
      2'd0: w_nib = r_snap[3:0];
      2'd1: begin
        w_nib   = r_snap[7:4];
        w_blank = bus.blank_lz && (r_snap[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = r_snap[11:8];
        w_blank = bus.blank_lz && (r_snap[15:8] == 8'h00);
      end
      default: begin
        w_nib   = r_snap[15:12];
        w_blank = bus.blank_lz && (r_snap[15:12] == 4'h0);
      end
    endcase
  end

  // Segments keep decoding during the guard time; only the anodes are held off.
  always_comb begin
    w_an  = 4'b1111;
    w_seg = hex_to_seg(w_nib);
    w_dp  = ~bus.dp_in[r_digit];
    if (w_blank) begin
      w_seg = 7'b1111111;
      w_dp  = 1'b1;
    end else if (!w_in_guard) begin
      w_an = ~(4'b0001 << r_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= 2'd0;
      r_snap  <= 16'h0000;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
      r_dp    <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_digit <= r_digit + 2'd1;
        if (r_digit == 2'd3) begin
          r_snap <= bus.value;
        end
      end
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
